// File: rtl/ifu_fetch.sv
// ----------------------------------------------------------------------------
// ifu_fetch -- single-issue instruction fetch unit.
//
// Fetches one 32-bit word from a combinational instruction memory, presents
// it to decode with a valid/ready handshake, and advances the PC by 4 after
// each accepted instruction. A redirect (branch/jump/trap) overrides
// everything except reset. Misaligned PCs produce a fault entry with no
// memory read.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   imem_en/_addr   - instruction memory read enable / byte address
//   imem_rdata      - instruction word, valid in the same cycle as the request
//   out_valid/ready - handshake to decode
//   out_pc/_inst    - PC and word of the presented entry
//   out_fault       - presented entry is a misaligned-fetch fault (inst = 0)
//   redirect_valid  - redirect request; redirect_pc is the new target
//   fetch_cnt       - number of accepted handshakes (wraps)
// ----------------------------------------------------------------------------
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] fetch_cnt
);

    typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] opc_q, opc_d;
    logic [31:0] inst_q, inst_d;
    logic        fault_q, fault_d;
    logic [31:0] cnt_q, cnt_d;

    logic aligned;
    logic handshake;

    assign aligned   = (pc_q[1:0] == 2'b00);
    assign handshake = (state_q == HOLD) && valid_q && out_ready;

    // Memory read only when actually fetching an aligned word.
    assign imem_en   = (state_q == FETCH) && !rst && aligned;
    assign imem_addr = pc_q;

    assign out_valid = valid_q;
    assign out_pc    = opc_q;
    assign out_inst  = inst_q;
    assign out_fault = fault_q;
    assign fetch_cnt = cnt_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        opc_d   = opc_q;
        inst_d  = inst_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;

        if (redirect_valid) begin
            // A handshake in the same cycle still counts; the redirect
            // target replaces the sequential pc+4.
            if (handshake) cnt_d = cnt_q + 32'd1;
            pc_d    = redirect_pc;
            valid_d = 1'b0;
            fault_d = 1'b0;
            state_d = FETCH;
        end else begin
            unique case (state_q)
                FETCH: begin
                    valid_d = 1'b1;
                    opc_d   = pc_q;
                    inst_d  = aligned ? imem_rdata : 32'd0;
                    fault_d = !aligned;
                    state_d = HOLD;
                end
                HOLD: begin
                    if (handshake) begin
                        pc_d    = opc_q + 32'd4;
                        valid_d = 1'b0;
                        cnt_d   = cnt_q + 32'd1;
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            opc_q   <= 32'd0;
            inst_q  <= 32'd0;
            fault_q <= 1'b0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            opc_q   <= opc_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_fault;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Instruction memory contents: low half of the address, then 16'h0413.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], 16'h0413};
    endfunction

    assign imem_rdata = mem(imem_addr);

    ifu_fetch #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_fault(out_fault),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_cnt(fetch_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: either an entry is being presented (m_valid)
    // or the unit is about to fetch m_pc.
    logic        m_valid = 1'b0;
    logic [31:0] m_pc    = RPC;
    logic [31:0] m_opc   = '0;
    logic [31:0] m_inst  = '0;
    logic        m_fault = 1'b0;
    logic [31:0] m_cnt   = '0;
    logic        m_live  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0; m_pc <= RPC; m_cnt <= '0; m_fault <= 1'b0;
            m_live  <= 1'b1;
        end else if (redirect_valid) begin
            if (m_valid && out_ready) m_cnt <= m_cnt + 1;
            m_pc <= redirect_pc; m_valid <= 1'b0; m_fault <= 1'b0;
        end else if (!m_valid) begin
            m_valid <= 1'b1;
            m_opc   <= m_pc;
            m_inst  <= (m_pc[1:0] == 2'b00) ? mem(m_pc) : 32'd0;
            m_fault <= (m_pc[1:0] != 2'b00);
        end else if (out_ready) begin
            m_pc <= m_opc + 32'd4; m_valid <= 1'b0; m_cnt <= m_cnt + 1;
        end
    end

    // Per-cycle comparison on the falling edge once the model has seen reset.
    always @(negedge clk) begin
        if (m_live) begin
            chk("m_imem_en", {31'd0, imem_en},
                {31'd0, !rst && !m_valid && (m_pc[1:0] == 2'b00)});
            chk("m_imem_addr", imem_addr, m_pc);
            chk("m_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            chk("m_fetch_cnt", fetch_cnt, m_cnt);
            if (m_valid) begin
                chk("m_out_pc", out_pc, m_opc);
                chk("m_out_inst", out_inst, m_inst);
                chk("m_out_fault", {31'd0, out_fault}, {31'd0, m_fault});
            end
        end
    end

    // Advance one clock; inputs are changed and literals sampled at posedge+2.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        tick(); tick();
        // Reset state
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_cnt", fetch_cnt, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_inst", out_inst, 32'd0);
        chk("rst_fault", {31'd0, out_fault}, 32'd0);
        chk("rst_en_low", {31'd0, imem_en}, 32'd0);

        // First fetch after release
        rst = 1'b0; out_ready = 1'b1; #1;
        chk("first_en", {31'd0, imem_en}, 32'd1);
        chk("first_addr", imem_addr, 32'h8000_0000);
        tick();
        chk("first_valid", {31'd0, out_valid}, 32'd1);
        chk("first_pc", out_pc, 32'h8000_0000);
        chk("first_inst", out_inst, 32'h0000_0413);
        tick();
        chk("bubble_valid", {31'd0, out_valid}, 32'd0);
        chk("hs1_cnt", fetch_cnt, 32'd1);
        chk("hs1_addr", imem_addr, 32'h8000_0004);

        // Hold for 5 cycles with out_ready low
        out_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_pc", out_pc, 32'h8000_0004);
            chk("hold_inst", out_inst, 32'h0004_0413);
            chk("hold_en", {31'd0, imem_en}, 32'd0);
            chk("hold_cnt", fetch_cnt, 32'd1);
            tick();
        end
        out_ready = 1'b1; tick();
        chk("hs2_cnt", fetch_cnt, 32'd2);
        out_ready = 1'b0; tick();
        chk("hold8_pc", out_pc, 32'h8000_0008);

        // Redirect discards the held 8000_0008
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0100; tick();
        chk("redir_valid", {31'd0, out_valid}, 32'd0);
        chk("redir_addr", imem_addr, 32'h8000_0100);
        chk("redir_cnt", fetch_cnt, 32'd2);
        redirect_valid = 1'b0; tick();
        chk("redir_pc", out_pc, 32'h8000_0100);
        chk("redir_inst", out_inst, 32'h0100_0413);

        // Redirect and handshake in the same cycle
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0040; tick();
        chk("rh_cnt", fetch_cnt, 32'd3);
        chk("rh_addr", imem_addr, 32'h8000_0040);

        // Misaligned redirect target
        out_ready = 1'b0; redirect_pc = 32'h8000_0102; tick();
        chk("mis_en", {31'd0, imem_en}, 32'd0);
        redirect_valid = 1'b0; tick();
        chk("mis_valid", {31'd0, out_valid}, 32'd1);
        chk("mis_fault", {31'd0, out_fault}, 32'd1);
        chk("mis_inst", out_inst, 32'd0);
        chk("mis_pc", out_pc, 32'h8000_0102);
        out_ready = 1'b1; tick();
        chk("mis_next", imem_addr, 32'h8000_0106);
        chk("mis_cnt", fetch_cnt, 32'd4);

        // Reset while holding 8000_0020
        out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8000_0020; tick();
        redirect_valid = 1'b0; tick();
        chk("h20_pc", out_pc, 32'h8000_0020);
        rst = 1'b1; tick();
        rst = 1'b0; #1;
        chk("rsth_valid", {31'd0, out_valid}, 32'd0);
        chk("rsth_cnt", fetch_cnt, 32'd0);
        chk("rsth_addr", imem_addr, 32'h8000_0000);
        tick();

        // PC wrap-around FFFF_FFFC + 4 = 0
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; tick();
        redirect_valid = 1'b0; tick();
        chk("wrap_pc", out_pc, 32'hFFFF_FFFC);
        out_ready = 1'b1; tick();
        chk("wrap_addr", imem_addr, 32'h0000_0000);

        // Reset beats redirect and handshake in the same cycle
        tick();
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0200; tick();
        rst = 1'b0; redirect_valid = 1'b0; #1;
        chk("rstpri_addr", imem_addr, 32'h8000_0000);
        chk("rstpri_cnt", fetch_cnt, 32'd0);
        tick();

        // Mixed traffic, checked by the model every cycle
        for (int i = 0; i < 60; i++) begin
            out_ready      = (i % 3) != 0;
            redirect_valid = (i % 11) == 5;
            redirect_pc    = 32'h8000_1000 + 32'(i) * 32'd6;
            tick();
        end
        redirect_valid = 1'b0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h8000_0000, the first fetch address after reset.
REQ-002 SHALL provide port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port imem_en  output  1  instruction-memory read enable.
REQ-005 SHALL provide port imem_addr  output  32  instruction-memory byte address.
REQ-006 SHALL provide port imem_rdata  input  32  instruction word, combinationally valid in the same cycle as imem_en/imem_addr.
REQ-007 SHALL provide port out_valid  output  1  fetched instruction available to decode.
REQ-008 SHALL provide port out_ready  input  1  decode accepts the current instruction.
REQ-009 SHALL provide port out_pc  output  32  PC of the presented instruction.
REQ-010 SHALL provide port out_inst  output  32  presented instruction word.
REQ-011 SHALL provide port out_fault  output  1  presented entry is a misaligned-fetch fault; out_inst is 0.
REQ-012 SHALL provide port redirect_valid  input  1  branch/jump/trap redirect request.
REQ-013 SHALL provide port redirect_pc  input  32  redirect target.
REQ-014 SHALL provide port fetch_cnt  output  32  count of accepted handshakes.

Function
REQ-015 SHALL implement a two-state FSM: FETCH and HOLD.
REQ-016 SHALL drive imem_en high only in FETCH, while rst is low, and while pc[1:0] equals 2'b00.
REQ-017 SHALL drive imem_addr equal to the internal pc register in all states.
REQ-018 In FETCH with no redirect, SHALL capture imem_rdata into out_inst and pc into out_pc at the clock edge, set out_valid, and move to HOLD; latency from entering FETCH to out_valid is 1 cycle.
REQ-019 In FETCH with pc[1:0] not 2'b00, SHALL issue no memory read, capture out_inst=0, out_fault=1, out_pc=pc, set out_valid, and move to HOLD.
REQ-020 In HOLD, SHALL keep out_valid, out_pc, out_inst and out_fault stable until out_ready is high.
REQ-021 In HOLD with out_valid and out_ready high, SHALL set pc to out_pc+4 (32-bit wrap-around, FFFF_FFFC+4 = 0), clear out_valid, increment fetch_cnt, and return to FETCH.
REQ-022 SHALL sustain at most one instruction per two cycles; a bubble cycle (out_valid=0) follows every handshake.
REQ-023 SHALL give redirect_valid priority over all other events in either state: pc <= redirect_pc, out_valid <= 0, out_fault <= 0, state <= FETCH.
REQ-024 When redirect_valid and an out_ready handshake occur in the same cycle, SHALL count the handshake in fetch_cnt and take the redirect target as the next pc (no pc+4).
REQ-025 SHALL discard a held instruction on redirect; it is never presented again.
REQ-026 SHALL accept a misaligned redirect_pc unmodified; the fault is reported per REQ-019.
REQ-027 SHALL let fetch_cnt wrap from FFFF_FFFF to 0 without saturation.
REQ-028 SHALL keep out_valid independent of out_ready combinationally (no combinational path from out_ready to any output).

Reset
REQ-029 While rst is high at a clock edge, SHALL set pc=RESET_PC, state=FETCH, out_valid=0, out_fault=0, out_inst=0, out_pc=0, fetch_cnt=0.
REQ-030 SHALL hold imem_en low during any cycle rst is high.
REQ-031 Reset asserted in HOLD SHALL drop the held instruction; the first fetch after release is RESET_PC.
REQ-032 Reset SHALL take priority over redirect_valid and out_ready in the same cycle.

Verification
REQ-033 Reset release, imem returns 32'h0000_0413 at 8000_0000, out_ready=1 -> out_valid=1 next cycle with out_pc=8000_0000, out_inst=0000_0413; next fetch addr 8000_0004; fetch_cnt=1.
REQ-034 out_ready held low 5 cycles in HOLD -> out_valid/out_pc/out_inst stable all 5 cycles, imem_en=0, fetch_cnt unchanged.
REQ-035 redirect_valid=1, redirect_pc=8000_0100 while holding 8000_0008 -> out_valid=0 next cycle, following fetch at 8000_0100, 8000_0008 never accepted.
REQ-036 Redirect and handshake same cycle, redirect_pc=8000_0040 -> fetch_cnt increments by 1, next imem_addr=8000_0040.
REQ-037 redirect_pc=8000_0102 -> imem_en stays 0, out_valid=1, out_fault=1, out_inst=0, out_pc=8000_0102.
REQ-038 rst pulsed in HOLD with pc=8000_0020 -> out_valid=0, fetch_cnt=0, next imem_addr=8000_0000.
